// File: rtl/snake_pkg.sv
// Shared constants and types for the snake field read path: field geometry, cell encoding,
// reader FSM states and the hex-to-seven-segment table.
package snake_pkg;

  localparam int unsigned FIELD_W = 8;
  localparam int unsigned FIELD_H = 8;
  localparam int unsigned CELL_W  = 2;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned ROW_W   = 3;
  localparam int unsigned COL_W   = 3;

  localparam logic [CELL_W-1:0] CELL_EMPTY = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StSend,
    StDone
  } reader_state_e;

  // Entry n is {g,f,e,d,c,b,a} for hex digit n; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] HEX7SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/snake_field_reader_if.sv
// Field-store read bus and row stream between the field reader, the store and the display.
interface snake_field_reader_if;

  logic                              rd_en;
  logic [snake_pkg::ADDR_W-1:0]      rd_addr;
  logic [snake_pkg::CELL_W-1:0]      rd_data;
  logic                              row_valid;
  logic                              row_ready;
  logic [snake_pkg::ROW_W-1:0]       row_idx;
  logic [snake_pkg::FIELD_W-1:0]     row_bits;

  modport master (
    output rd_en, rd_addr, row_valid, row_idx, row_bits,
    input  rd_data, row_ready
  );

  modport slave (
    input  rd_en, rd_addr, row_valid, row_idx, row_bits,
    output rd_data, row_ready
  );

endinterface

// File: rtl/snake_hex7seg.sv
// Combinational hex nibble to active-high {g..a} segment pattern.
module snake_hex7seg
  import snake_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX7SEG[nibble];

endmodule

// File: rtl/snake_field_reader.sv
// Scans the 8x8 snake field row by row, streams packed row bitmaps and shows the
// per-frame occupied-cell count on a seven-segment digit.
module snake_field_reader
  import snake_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  output logic                 busy,
  snake_field_reader_if.master bus,
  output logic                 frame_done,
  output logic                 segA,
  output logic                 segB,
  output logic                 segC,
  output logic                 segD,
  output logic                 segE,
  output logic                 segF,
  output logic                 segG,
  output logic                 segDP
);

  localparam logic [COL_W-1:0] LastCol  = COL_W'(FIELD_W - 1);
  localparam logic [ROW_W-1:0] LastRow  = ROW_W'(FIELD_H - 1);
  localparam logic [6:0]       MaxCount = 7'(FIELD_W * FIELD_H);

  reader_state_e      state_q;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  logic               rd_en_q;
  logic               samp_q;
  logic [FIELD_W-1:0] shreg_q;
  logic [FIELD_W-1:0] row_bits_q;
  logic               row_valid_q;
  logic               busy_q;
  logic               done_q;
  logic [6:0]         count_q;
  logic [6:0]         seg_q;
  logic               dp_q;

  logic               occ;
  logic [FIELD_W-1:0] shift_nxt;
  logic [6:0]         seg_nxt;

  // Columns arrive in order 0..7, so shifting in at the MSB leaves column c at bit c.
  assign occ       = (bus.rd_data != CELL_EMPTY);
  assign shift_nxt = {occ, shreg_q[FIELD_W-1:1]};

  snake_hex7seg u_hex7seg (
    .nibble (count_q[3:0]),
    .seg    (seg_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      rd_en_q     <= 1'b0;
      samp_q      <= 1'b0;
      shreg_q     <= '0;
      row_bits_q  <= '0;
      row_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
      seg_q       <= '0;
      dp_q        <= 1'b0;
    end else begin
      // Store has one cycle of read latency: sample the cycle after each strobe.
      samp_q <= rd_en_q;
      if (samp_q) begin
        shreg_q <= shift_nxt;
        if (occ && (count_q < MaxCount)) begin
          count_q <= count_q + 7'd1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            state_q <= StRead;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
            col_q   <= '0;
            row_q   <= '0;
            count_q <= '0;
          end
        end
        StRead: begin
          if (col_q == LastCol) begin
            rd_en_q <= 1'b0;
            state_q <= StWait;
          end else begin
            col_q <= col_q + COL_W'(1);
          end
        end
        StWait: begin
          state_q     <= StSend;
          row_valid_q <= 1'b1;
          row_bits_q  <= shift_nxt;
        end
        StSend: begin
          if (bus.row_ready) begin
            row_valid_q <= 1'b0;
            if (row_q == LastRow) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              seg_q   <= seg_nxt;
              dp_q    <= (count_q > 7'd15);
            end else begin
              state_q <= StRead;
              row_q   <= row_q + ROW_W'(1);
              col_q   <= '0;
              rd_en_q <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = {row_q, col_q};
  assign bus.row_valid = row_valid_q;
  assign bus.row_idx   = row_q;
  assign bus.row_bits  = row_bits_q;

  assign segA  = seg_q[0];
  assign segB  = seg_q[1];
  assign segC  = seg_q[2];
  assign segD  = seg_q[3];
  assign segE  = seg_q[4];
  assign segF  = seg_q[5];
  assign segG  = seg_q[6];
  assign segDP = dp_q;

endmodule

// File: tb/tb_snake_field_reader.sv
// Self-checking bench for snake_field_reader: field-store model, row scoreboard and
// directed frame scenarios.
module tb_snake_field_reader;
  import snake_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic busy, frame_done;
  logic segA, segB, segC, segD, segE, segF, segG, segDP;

  snake_field_reader_if bus ();

  snake_field_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .busy        (busy),
    .bus         (bus),
    .frame_done  (frame_done),
    .segA        (segA),
    .segB        (segB),
    .segC        (segC),
    .segD        (segD),
    .segE        (segE),
    .segF        (segF),
    .segG        (segG),
    .segDP       (segDP)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] bits;
  } row_t;

  logic [1:0] field [64];
  row_t       sb [$];
  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;
  int         exp_done = 0;

  // Synchronous-read field store
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= field[bus.rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int field_count();
    int n = 0;
    for (int i = 0; i < 64; i++) if (field[i] != 2'b00) n++;
    return n;
  endfunction

  task automatic push_frame();
    row_t e;
    for (int r = 0; r < 8; r++) begin
      e.idx = 3'(r);
      for (int c = 0; c < 8; c++) e.bits[c] = (field[r*8+c] != 2'b00);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    exp_done++;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    int n;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      n = field_count();
      check({tag, "_seg"}, {segG, segF, segE, segD, segC, segB, segA}, SEG_TAB[n % 16]);
      check({tag, "_segdp"}, segDP, (n > 15));
      check({tag, "_busy_in_done"}, busy, 1'b1);
      // A start pulse in the done cycle must not launch another frame
      frame_start = 1'b1;
      @(posedge clk);
      #1 frame_start = 1'b0;
    end
    repeat (3) @(negedge clk);
    check({tag, "_busy_idle"}, busy, 1'b0);
    check({tag, "_done_cnt"}, done_cnt, exp_done);
  endtask

  // Row monitor: each negedge with valid && ready precedes exactly one handshake edge
  always @(negedge clk) begin
    row_t e;
    if (rst_n) begin
      if (frame_done) done_cnt++;
      if (bus.row_valid && bus.row_ready) begin
        if (sb.size() == 0) begin
          check("row_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("row_idx", bus.row_idx, e.idx);
          check("row_bits", bus.row_bits, e.bits);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] held;
    bit         ok;
    bus.row_ready = 1'b1;
    for (int i = 0; i < 64; i++) field[i] = 2'b00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", bus.rd_en, 1'b0);
    check("rst_row_valid", bus.row_valid, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_seg", {segDP, segG, segF, segE, segD, segC, segB, segA}, 8'h00);
    check("rst_rd_addr", bus.rd_addr, 6'd0);
    check("rst_row_idx", bus.row_idx, 3'd0);
    check("rst_row_bits", bus.row_bits, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Empty field, with start and row latency checks
    push_frame();
    @(posedge clk);
    #1 frame_start = 1'b1;
    @(negedge clk);
    check("lat_rd_en_c0", bus.rd_en, 1'b0);
    @(posedge clk);
    #1 frame_start = 1'b0;
    exp_done++;
    @(negedge clk);
    check("lat_rd_en_c1", bus.rd_en, 1'b1);
    check("lat_rd_addr_c1", bus.rd_addr, 6'd0);
    check("lat_busy_c1", busy, 1'b1);
    repeat (8) @(negedge clk);
    check("lat_row_valid_c9", bus.row_valid, 1'b0);
    check("lat_rd_en_c9", bus.rd_en, 1'b0);
    @(negedge clk);
    check("lat_row_valid_c10", bus.row_valid, 1'b1);
    wait_done("empty");

    // Three occupied cells
    for (int i = 0; i < 64; i++) field[i] = 2'b00;
    field[0] = 2'b01;
    field[1] = 2'b01;
    field[3*8+7] = 2'b01;
    push_frame();
    pulse_start();
    wait_done("pattern");

    // Every cell occupied
    for (int i = 0; i < 64; i++) field[i] = 2'($urandom_range(1, 3));
    push_frame();
    pulse_start();
    wait_done("full");

    // Backpressure on row 2
    for (int i = 0; i < 64; i++) field[i] = 2'($urandom_range(0, 3));
    push_frame();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.row_valid && bus.row_idx == 3'd1) ok = 1'b1;
    end
    check("stall_row1_seen", 32'(ok), 32'd1);
    @(posedge clk);
    #1 bus.row_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.row_valid) ok = 1'b1;
    end
    check("stall_row2_seen", 32'(ok), 32'd1);
    check("stall_row_idx", bus.row_idx, 3'd2);
    held = bus.row_bits;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!bus.row_valid || bus.row_bits !== held || bus.rd_en) ok = 1'b0;
    end
    check("stall_hold", 32'(ok), 32'd1);
    @(posedge clk);
    #1 bus.row_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("resume_rd_en", bus.rd_en, 1'b1);
    check("resume_rd_addr", bus.rd_addr, 6'd24);
    wait_done("stall");

    // Start pulses while busy are ignored
    for (int i = 0; i < 64; i++) field[i] = 2'($urandom_range(0, 3));
    push_frame();
    pulse_start();
    repeat (5) begin
      repeat (13) @(posedge clk);
      #1 frame_start = 1'b1;
      @(posedge clk);
      #1 frame_start = 1'b0;
    end
    wait_done("busy_pulses");

    // Reset in the middle of row 4, then a clean restart
    for (int i = 0; i < 64; i++) field[i] = 2'($urandom_range(0, 3));
    push_frame();
    pulse_start();
    exp_done--;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (bus.rd_en && bus.rd_addr == 6'd35) ok = 1'b1;
    end
    check("midrst_row4_seen", 32'(ok), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_rd_en", bus.rd_en, 1'b0);
    check("midrst_row_valid", bus.row_valid, 1'b0);
    check("midrst_addr_idx_bits", {bus.rd_addr, bus.row_idx, bus.row_bits}, 17'd0);
    check("midrst_seg", {segDP, segG, segF, segE, segD, segC, segB, segA}, 8'h00);
    check("midrst_sb_left", sb.size(), 4);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_frame();
    pulse_start();
    wait_done("restart");
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
